// File: rtl/noc_initiator_if.sv
// Request/response and NoC byte-link signals of the NoC initiator.
// The initiator block uses the slave modport; its requester and switch use master.
interface noc_initiator_if;
   logic        noc_to_dev_ctl;
   logic [7:0]  noc_to_dev_data;
   logic        noc_from_dev_ctl;
   logic [7:0]  noc_from_dev_data;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_dest;
   logic [31:0] req_addr;
   logic [1:0]  req_alen;
   logic [1:0]  req_dlen;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [7:0]  rsp_cmd;
   logic [63:0] rsp_rdata;

   modport slave (
      output noc_to_dev_ctl, noc_to_dev_data, req_ready,
             rsp_valid, rsp_err, rsp_cmd, rsp_rdata,
      input  noc_from_dev_ctl, noc_from_dev_data, req_valid, req_write,
             req_dest, req_addr, req_alen, req_dlen, req_wdata
   );

   modport master (
      input  noc_to_dev_ctl, noc_to_dev_data, req_ready,
             rsp_valid, rsp_err, rsp_cmd, rsp_rdata,
      output noc_from_dev_ctl, noc_from_dev_data, req_valid, req_write,
             req_dest, req_addr, req_alen, req_dlen, req_wdata
   );
endinterface

// File: rtl/noc_initiator.sv
// NoC initiator: serialises one read/write request into a byte packet toward
// the switch, then collects the response packet and reports completion.
module noc_initiator #(
   parameter int TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           reset,
   noc_initiator_if.slave bus
);
   typedef enum logic [2:0] {IDLE, HDR, DEST, ADDR, WDAT, WAIT, RESP} state_t;

   localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic [9:0]  tcnt, tcnt_n;
   logic        rx_full, rx_full_n;
   logic        rx_ovf, rx_ovf_n;
   logic        wr_q, wr_n;
   logic [7:0]  dest_q, dest_n;
   logic [31:0] addr_q, addr_n;
   logic [1:0]  alen_q, alen_n;
   logic [1:0]  dlen_q, dlen_n;
   logic [63:0] wdata_q, wdata_n;
   logic        tx_ctl_n;
   logic [7:0]  tx_data_n;
   logic        ready_n;
   logic        rsp_valid_n;
   logic        rsp_err_n;
   logic [7:0]  rsp_cmd_n;
   logic [63:0] rsp_rdata_n;
   logic        accept;
   logic        rx_bad;
   logic [2:0]  alast;
   logic [2:0]  dlast;
   logic [3:0]  dbytes;

   assign accept = bus.req_valid && bus.req_ready;
   assign alast  = 3'((4'd1 << alen_q) - 4'd1);
   assign dlast  = 3'((4'd1 << dlen_q) - 4'd1);
   assign dbytes = 4'd1 << dlen_q;

   // rx_full marks that all eight rdata slots are used (cnt has wrapped to 0)
   always_comb begin
      if (wr_q) begin
         rx_bad = (bus.rsp_cmd[2:0] != 3'b100) || rx_full || (cnt != 3'd0);
      end else begin
         rx_bad = (bus.rsp_cmd[2:0] != 3'b011) || rx_ovf ||
                  (rx_full ? (dlen_q != 2'b11) : ({1'b0, cnt} != dbytes));
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      tcnt_n      = tcnt;
      rx_full_n   = rx_full;
      rx_ovf_n    = rx_ovf;
      wr_n        = wr_q;
      dest_n      = dest_q;
      addr_n      = addr_q;
      alen_n      = alen_q;
      dlen_n      = dlen_q;
      wdata_n     = wdata_q;
      tx_ctl_n    = 1'b1;
      tx_data_n   = 8'h00;
      rsp_valid_n = 1'b0;
      rsp_err_n   = 1'b0;
      rsp_cmd_n   = bus.rsp_cmd;
      rsp_rdata_n = bus.rsp_rdata;

      // Wire outputs are registered, so each branch drives the byte of the state being entered
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.req_alen == 2'b11) begin
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_cmd_n   = 8'h00;
                  rsp_rdata_n = 64'h0;
               end else begin
                  state_n   = HDR;
                  cnt_n     = 3'd0;
                  wr_n      = bus.req_write;
                  dest_n    = bus.req_dest;
                  addr_n    = bus.req_addr;
                  alen_n    = bus.req_alen;
                  dlen_n    = bus.req_dlen;
                  wdata_n   = bus.req_wdata;
                  tx_data_n = {1'b0, bus.req_dlen, bus.req_alen,
                               bus.req_write ? 3'b010 : 3'b001};
               end
            end
         end
         HDR: begin
            state_n   = DEST;
            cnt_n     = 3'd0;
            tx_ctl_n  = 1'b0;
            tx_data_n = dest_q;
         end
         DEST: begin
            state_n   = ADDR;
            cnt_n     = 3'd0;
            tx_ctl_n  = 1'b0;
            tx_data_n = addr_q[7:0];
         end
         ADDR: begin
            if (cnt == alast) begin
               cnt_n  = 3'd0;
               tcnt_n = 10'd0;
               if (wr_q) begin
                  state_n   = WDAT;
                  tx_ctl_n  = 1'b0;
                  tx_data_n = wdata_q[7:0];
               end else begin
                  state_n = WAIT;
               end
            end else begin
               cnt_n     = cnt + 3'd1;
               tx_ctl_n  = 1'b0;
               tx_data_n = addr_q[{cnt_n[1:0], 3'b000} +: 8];
            end
         end
         WDAT: begin
            if (cnt == dlast) begin
               state_n = WAIT;
               cnt_n   = 3'd0;
               tcnt_n  = 10'd0;
            end else begin
               cnt_n     = cnt + 3'd1;
               tx_ctl_n  = 1'b0;
               tx_data_n = wdata_q[{cnt_n, 3'b000} +: 8];
            end
         end
         WAIT: begin
            tcnt_n = tcnt + 10'd1;
            if (bus.noc_from_dev_ctl && (bus.noc_from_dev_data != 8'h00)) begin
               state_n     = RESP;
               rsp_cmd_n   = bus.noc_from_dev_data;
               rsp_rdata_n = 64'h0;
               cnt_n       = 3'd0;
               tcnt_n      = 10'd0;
               rx_full_n   = 1'b0;
               rx_ovf_n    = 1'b0;
            end else if (tcnt_n == TO_LIM) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
               rsp_cmd_n   = 8'h00;
            end
         end
         RESP: begin
            if (!bus.noc_from_dev_ctl) begin
               if (rx_full) begin
                  rx_ovf_n = 1'b1;
               end else begin
                  rsp_rdata_n[{cnt, 3'b000} +: 8] = bus.noc_from_dev_data;
                  cnt_n = cnt + 3'd1;
                  if (cnt == 3'd7) rx_full_n = 1'b1;
               end
            end else begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               rsp_err_n   = rx_bad || (bus.noc_from_dev_data != 8'h00);
            end
         end
         default: state_n = IDLE;
      endcase

      // Hold off the next request during the completion pulse
      ready_n = (state_n == IDLE) && !rsp_valid_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state               <= IDLE;
         cnt                 <= 3'd0;
         tcnt                <= 10'd0;
         rx_full             <= 1'b0;
         rx_ovf              <= 1'b0;
         bus.noc_to_dev_ctl  <= 1'b1;
         bus.noc_to_dev_data <= 8'h00;
         bus.req_ready       <= 1'b0;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_err         <= 1'b0;
         bus.rsp_cmd         <= 8'h00;
         bus.rsp_rdata       <= 64'h0;
      end else begin
         state               <= state_n;
         cnt                 <= cnt_n;
         tcnt                <= tcnt_n;
         rx_full             <= rx_full_n;
         rx_ovf              <= rx_ovf_n;
         bus.noc_to_dev_ctl  <= tx_ctl_n;
         bus.noc_to_dev_data <= tx_data_n;
         bus.req_ready       <= ready_n;
         bus.rsp_valid       <= rsp_valid_n;
         bus.rsp_err         <= rsp_err_n;
         bus.rsp_cmd         <= rsp_cmd_n;
         bus.rsp_rdata       <= rsp_rdata_n;
      end
   end

   always_ff @(posedge clk) begin
      wr_q    <= wr_n;
      dest_q  <= dest_n;
      addr_q  <= addr_n;
      alen_q  <= alen_n;
      dlen_q  <= dlen_n;
      wdata_q <= wdata_n;
   end
endmodule

// File: tb/tb_noc_initiator.sv
// Directed bench for noc_initiator: packet bytes on the wire, response
// collection, error cases, timeout, reset abort and illegal address length.
module tb_noc_initiator;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   noc_initiator_if bus();

   noc_initiator #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wexp(input string tag, input logic c, input logic [7:0] d);
      chk(tag, 64'({bus.noc_to_dev_ctl, bus.noc_to_dev_data}), 64'({c, d}));
      tick();
   endtask

   task automatic issue(input logic w, input logic [7:0] dest, input logic [31:0] addr,
                        input logic [1:0] alen, input logic [1:0] dlen, input logic [63:0] wd);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_dest  = dest;
      bus.req_addr  = addr;
      bus.req_alen  = alen;
      bus.req_dlen  = dlen;
      bus.req_wdata = wd;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic rx(input logic c, input logic [7:0] d);
      bus.noc_from_dev_ctl  = c;
      bus.noc_from_dev_data = d;
      tick();
      bus.noc_from_dev_ctl  = 1'b1;
      bus.noc_from_dev_data = 8'h00;
   endtask

   task automatic done(input string tag, input logic err, input logic [7:0] cmd,
                       input logic [63:0] rd);
      chk({tag, "_vld"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, "_err"}, 64'(bus.rsp_err), 64'(err));
      chk({tag, "_cmd"}, 64'(bus.rsp_cmd), 64'(cmd));
      chk({tag, "_rdata"}, bus.rsp_rdata, rd);
      chk({tag, "_rdy_lo"}, 64'(bus.req_ready), 64'd0);
      tick();
      chk({tag, "_pulse"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_rdy_hi"}, 64'(bus.req_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      reset = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_dest  = 8'h00;
      bus.req_addr  = 32'h0;
      bus.req_alen  = 2'b00;
      bus.req_dlen  = 2'b00;
      bus.req_wdata = 64'h0;
      bus.noc_from_dev_ctl  = 1'b1;
      bus.noc_from_dev_data = 8'h00;
      repeat (2) tick();
      chk("rst_wire", 64'({bus.noc_to_dev_ctl, bus.noc_to_dev_data}), 64'h100);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_vld", 64'(bus.rsp_valid), 64'd0);
      chk("rst_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_cmd", 64'(bus.rsp_cmd), 64'd0);
      chk("rst_rdata", bus.rsp_rdata, 64'd0);
      reset = 1'b1;
      chk("rdy_before_edge", 64'(bus.req_ready), 64'd0);
      tick();
      chk("rdy_first_edge", 64'(bus.req_ready), 64'd1);

      // write, 1 addr byte, 2 data bytes; switch noise during transmit must be ignored
      issue(1'b1, 8'h40, 32'h12, 2'b00, 2'b01, 64'hBEEF);
      bus.noc_from_dev_ctl  = 1'b1;
      bus.noc_from_dev_data = 8'h07;
      chk("wr_rdy_busy", 64'(bus.req_ready), 64'd0);
      wexp("wr_hdr", 1'b1, 8'h22);
      wexp("wr_dest", 1'b0, 8'h40);
      wexp("wr_addr0", 1'b0, 8'h12);
      wexp("wr_dat0", 1'b0, 8'hEF);
      wexp("wr_dat1", 1'b0, 8'hBE);
      bus.noc_from_dev_data = 8'h00;
      wexp("wr_nop", 1'b1, 8'h00);
      rx(1'b1, 8'h04);
      rx(1'b1, 8'h00);
      done("wr", 1'b0, 8'h04, 64'h0);

      // read, 4 addr bytes, 4 data bytes
      issue(1'b0, 8'h41, 32'hA0B0C0D0, 2'b10, 2'b10, 64'h0);
      wexp("rd_hdr", 1'b1, 8'h51);
      wexp("rd_dest", 1'b0, 8'h41);
      wexp("rd_addr0", 1'b0, 8'hD0);
      wexp("rd_addr1", 1'b0, 8'hC0);
      wexp("rd_addr2", 1'b0, 8'hB0);
      wexp("rd_addr3", 1'b0, 8'hA0);
      wexp("rd_nop", 1'b1, 8'h00);
      rx(1'b1, 8'h03);
      rx(1'b0, 8'h11);
      rx(1'b0, 8'h22);
      rx(1'b0, 8'h33);
      rx(1'b0, 8'h44);
      rx(1'b1, 8'h00);
      done("rd4", 1'b0, 8'h03, 64'h44332211);

      // read of 4 answered with only 2 bytes
      issue(1'b0, 8'h41, 32'h55, 2'b00, 2'b10, 64'h0);
      wexp("sh_hdr", 1'b1, 8'h41);
      wexp("sh_dest", 1'b0, 8'h41);
      wexp("sh_addr0", 1'b0, 8'h55);
      wexp("sh_nop", 1'b1, 8'h00);
      rx(1'b1, 8'h03);
      rx(1'b0, 8'hAA);
      rx(1'b0, 8'hBB);
      rx(1'b1, 8'h00);
      done("rd_short", 1'b1, 8'h03, 64'hBBAA);

      // no response: completion 16 cycles after entering WAIT; a ctl=0 byte is ignored
      issue(1'b0, 8'h40, 32'h07, 2'b00, 2'b00, 64'h0);
      wexp("to_hdr", 1'b1, 8'h01);
      wexp("to_dest", 1'b0, 8'h40);
      wexp("to_addr0", 1'b0, 8'h07);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 40) begin
         bus.noc_from_dev_ctl  = (n != 3);
         bus.noc_from_dev_data = (n == 3) ? 8'h99 : 8'h00;
         tick();
         n++;
      end
      bus.noc_from_dev_ctl  = 1'b1;
      bus.noc_from_dev_data = 8'h00;
      chk("to_cycles", 64'(n), 64'd16);
      chk("to_err", 64'(bus.rsp_err), 64'd1);
      chk("to_cmd", 64'(bus.rsp_cmd), 64'd0);
      tick();
      chk("to_pulse", 64'(bus.rsp_valid), 64'd0);

      // write answered with a data byte
      issue(1'b1, 8'h40, 32'h33, 2'b00, 2'b00, 64'h5C);
      wexp("wd_hdr", 1'b1, 8'h02);
      wexp("wd_dest", 1'b0, 8'h40);
      wexp("wd_addr0", 1'b0, 8'h33);
      wexp("wd_dat0", 1'b0, 8'h5C);
      wexp("wd_nop", 1'b1, 8'h00);
      rx(1'b1, 8'h04);
      rx(1'b0, 8'h77);
      rx(1'b1, 8'h00);
      done("wr_data", 1'b1, 8'h04, 64'h77);

      // read answered with a write-response code
      issue(1'b0, 8'h40, 32'h01, 2'b00, 2'b00, 64'h0);
      wexp("bc_hdr", 1'b1, 8'h01);
      wexp("bc_dest", 1'b0, 8'h40);
      wexp("bc_addr0", 1'b0, 8'h01);
      wexp("bc_nop", 1'b1, 8'h00);
      rx(1'b1, 8'h04);
      rx(1'b0, 8'h01);
      rx(1'b1, 8'h00);
      done("rd_badcmd", 1'b1, 8'h04, 64'h01);

      // read of 8 with exactly 8 bytes, then with 9 (ninth dropped)
      issue(1'b0, 8'h41, 32'h09, 2'b00, 2'b11, 64'h0);
      wexp("r8_hdr", 1'b1, 8'h61);
      wexp("r8_dest", 1'b0, 8'h41);
      wexp("r8_addr0", 1'b0, 8'h09);
      rx(1'b1, 8'h03);
      for (int i = 1; i <= 8; i++) rx(1'b0, 8'(i));
      rx(1'b1, 8'h00);
      done("rd8", 1'b0, 8'h03, 64'h0807060504030201);

      issue(1'b0, 8'h41, 32'h09, 2'b00, 2'b11, 64'h0);
      wexp("ov_hdr", 1'b1, 8'h61);
      wexp("ov_dest", 1'b0, 8'h41);
      wexp("ov_addr0", 1'b0, 8'h09);
      rx(1'b1, 8'h03);
      for (int i = 1; i <= 9; i++) rx(1'b0, 8'(i));
      rx(1'b1, 8'h00);
      done("rd_ovf", 1'b1, 8'h03, 64'h0807060504030201);

      // nonzero ctl byte during RESP terminates with error and is discarded
      issue(1'b0, 8'h40, 32'h02, 2'b00, 2'b00, 64'h0);
      wexp("tm_hdr", 1'b1, 8'h01);
      wexp("tm_dest", 1'b0, 8'h40);
      wexp("tm_addr0", 1'b0, 8'h02);
      rx(1'b1, 8'h03);
      rx(1'b0, 8'h05);
      rx(1'b1, 8'h09);
      done("rd_term", 1'b1, 8'h03, 64'h05);

      // illegal address length: immediate error completion, nothing on the wire
      issue(1'b0, 8'h40, 32'h0, 2'b11, 2'b00, 64'h0);
      chk("il_vld", 64'(bus.rsp_valid), 64'd1);
      chk("il_err", 64'(bus.rsp_err), 64'd1);
      chk("il_wire", 64'({bus.noc_to_dev_ctl, bus.noc_to_dev_data}), 64'h100);
      chk("il_rdy", 64'(bus.req_ready), 64'd0);
      tick();
      chk("il_pulse", 64'(bus.rsp_valid), 64'd0);
      chk("il_wire2", 64'({bus.noc_to_dev_ctl, bus.noc_to_dev_data}), 64'h100);
      chk("il_rdy2", 64'(bus.req_ready), 64'd1);

      // reset during ADDR aborts at once, then a fresh read completes
      issue(1'b0, 8'h41, 32'h11223344, 2'b10, 2'b00, 64'h0);
      wexp("ra_hdr", 1'b1, 8'h11);
      wexp("ra_dest", 1'b0, 8'h41);
      chk("ra_addr0", 64'({bus.noc_to_dev_ctl, bus.noc_to_dev_data}), 64'h044);
      #2;
      reset = 1'b0;
      #1;
      chk("ra_async_wire", 64'({bus.noc_to_dev_ctl, bus.noc_to_dev_data}), 64'h100);
      chk("ra_async_rdy", 64'(bus.req_ready), 64'd0);
      chk("ra_async_cmd", 64'(bus.rsp_cmd), 64'd0);
      chk("ra_async_rdata", bus.rsp_rdata, 64'd0);
      tick();
      tick();
      chk("ra_no_vld", 64'(bus.rsp_valid), 64'd0);
      reset = 1'b1;
      tick();
      chk("ra_rdy", 64'(bus.req_ready), 64'd1);
      issue(1'b0, 8'h40, 32'h5A, 2'b00, 2'b00, 64'h0);
      wexp("pr_hdr", 1'b1, 8'h01);
      wexp("pr_dest", 1'b0, 8'h40);
      wexp("pr_addr0", 1'b0, 8'h5A);
      wexp("pr_nop", 1'b1, 8'h00);
      rx(1'b1, 8'h03);
      rx(1'b0, 8'hC3);
      rx(1'b1, 8'h00);
      done("post_rst", 1'b0, 8'h03, 64'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
